count_one_seq: RTL and testbench

Multi-cycle population counter for wide bit vectors. It accepts one DataWidth-bit vector over a valid/ready handshake. It then counts the vector ChunkWidth bits per cycle through a single `CountOne #(.InputWidth(ChunkWidth))` instance, accumulating into a running sum, and presents the total over an output valid/ready handshake. It is the sequential consumer of the `CountOne` combinational stage, used wherever a wide mask (free lists, ROB/LSQ occupancy masks) is too wide for a single-cycle popcount.

---
 rtl/count_one_seq.sv | 109 ++++++++++
 tb/tb_count_one_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_one_seq.sv
// Multi-cycle population counter: accepts one wide vector over valid/ready and
// counts it ChunkWidth bits per cycle through a single CountOne stage.

module CountOne #(
  parameter int InputWidth = 8
) (
  input  logic [InputWidth-1:0]         data_i,
  output logic [$clog2(InputWidth+1)-1:0] cnt_o
);
  localparam int OutWidth = $clog2(InputWidth + 1);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < InputWidth; i++) begin
      cnt_o = cnt_o + OutWidth'(data_i[i]);
    end
  end
endmodule

module count_one_seq #(
  parameter int DataWidth  = 64,
  parameter int ChunkWidth = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [DataWidth-1:0]               data_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [$clog2(DataWidth+1)-1:0]     cnt_o
);
  localparam int NumChunks     = DataWidth / ChunkWidth;
  localparam int CountWidth    = $clog2(DataWidth + 1);
  localparam int ChunkCntWidth = $clog2(ChunkWidth + 1);
  localparam int IdxWidth      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumChunks - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [DataWidth-1:0]      data_q, data_d;
  logic [CountWidth-1:0]     acc_q, acc_d;
  logic [IdxWidth-1:0]       idx_q, idx_d;
  logic [ChunkCntWidth-1:0]  chunk_cnt;

  CountOne #(.InputWidth(ChunkWidth)) u_count_one (
    .data_i (data_q[ChunkWidth-1:0]),
    .cnt_o  (chunk_cnt)
  );

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign cnt_o   = acc_q;

  always_comb begin
    // NOTE: every target gets a hold value first so no path leaves one unassigned (no latches).
    state_d = state_q;
    data_d  = data_q;
    acc_d   = acc_q;
    idx_d   = idx_q;

    if (clear_i) begin
      state_d = IDLE;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            data_d  = data_i;
            acc_d   = '0;
            idx_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          acc_d  = acc_q + CountWidth'(chunk_cnt);
          data_d = data_q >> ChunkWidth;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LastIdx) state_d = DONE;
        end
        DONE: begin
          if (ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_count_one_seq.sv
// Self-checking bench for count_one_seq: directed cases on the 64/8 build, then
// randomized traffic on 64/8 and 8/8 builds checked against a bit-sum model.

module tb_count_one_seq;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        sel = 1'b0;

  logic       a_ready, a_valid;
  logic [6:0] a_cnt;
  logic       b_ready, b_valid;
  logic [3:0] b_cnt;

  logic       cur_ready, cur_valid;
  logic [6:0] cur_cnt;

  int total = 0;
  int bad   = 0;
  int nc    = 8;
  logic [63:0] mask = '1;

  always #5 clk = ~clk;

  count_one_seq #(.DataWidth(64), .ChunkWidth(8)) u_dut_a (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .valid_i (valid_i && !sel),
    .ready_o (a_ready),
    .data_i  (data_i),
    .valid_o (a_valid),
    .ready_i (ready_i && !sel),
    .cnt_o   (a_cnt)
  );

  count_one_seq #(.DataWidth(8), .ChunkWidth(8)) u_dut_b (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .valid_i (valid_i && sel),
    .ready_o (b_ready),
    .data_i  (data_i[7:0]),
    .valid_o (b_valid),
    .ready_i (ready_i && sel),
    .cnt_o   (b_cnt)
  );

  assign cur_ready = sel ? b_ready : a_ready;
  assign cur_valid = sel ? b_valid : a_valid;
  assign cur_cnt   = sel ? 7'(b_cnt) : a_cnt;

  function automatic int popcount(input logic [63:0] v);
    int s = 0;
    for (int i = 0; i < 64; i++) s += int'(v[i]);
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d);
    int n = 0;
    while (!cur_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cur_ready) check("send_ready_timeout", 64'(cur_ready), 64'd1);
    valid_i = 1'b1;
    data_i  = d;
    tick();
    valid_i = 1'b0;
    check("first_busy_cnt", 64'(cur_cnt), 64'd0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!cur_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  // Accept d, expect the result exp after the nominal latency, then consume it.
  task automatic run(input string tag, input logic [63:0] d, input int exp);
    int lat;
    ready_i = 1'b1;
    send(d);
    wait_valid(lat);
    check({tag, "_latency"}, 64'(lat), 64'(nc));
    check({tag, "_cnt"}, 64'(cur_cnt), 64'(exp));
    tick();
    check({tag, "_ready_after"}, 64'(cur_ready), 64'd1);
    check({tag, "_valid_after"}, 64'(cur_valid), 64'd0);
  endtask

  // Random valid/ready traffic; the model is a FIFO of accepted vectors and
  // the result for each is its bit count, due NumChunks+1 edges after accept.
  task automatic random_run(input string tag, input int n_vec);
    logic [63:0] q[$];
    int cyc = 0;
    int done_cnt = 0;
    int accept_cyc = 0;
    bit lat_pending = 1'b0;
    logic [63:0] head;
    while (done_cnt < n_vec && cyc < n_vec * 40) begin
      valid_i = ($urandom_range(3) != 0);
      ready_i = ($urandom_range(3) != 0);
      data_i  = {$urandom, $urandom};
      if ($urandom_range(7) == 0) data_i = '1;
      if ($urandom_range(7) == 0) data_i = '0;
      if (valid_i && cur_ready) begin
        q.push_back(data_i & mask);
        accept_cyc  = cyc;
        lat_pending = 1'b1;
      end
      if (cur_valid) begin
        if (lat_pending) begin
          check({tag, "_latency"}, 64'(cyc - accept_cyc), 64'(nc + 1));
          lat_pending = 1'b0;
        end
        if (ready_i) begin
          if (q.size() == 0) begin
            check({tag, "_unexpected_result"}, 64'(cur_cnt), 64'd0);
          end else begin
            head = q.pop_front();
            check({tag, "_cnt"}, 64'(cur_cnt), 64'(popcount(head)));
          end
          done_cnt++;
        end
      end
      tick();
      cyc++;
    end
    check({tag, "_completed"}, 64'(done_cnt), 64'(n_vec));
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    int  lat;
    bit  seen;

    // Reset
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_ready", 64'(cur_ready), 64'd1);
    check("rst_valid", 64'(cur_valid), 64'd0);
    check("rst_cnt", 64'(cur_cnt), 64'd0);

    // Basic patterns and chunk boundaries
    run("zeros", 64'h0, 0);
    run("ones", 64'hFFFF_FFFF_FFFF_FFFF, 64);
    run("ends", 64'h8000_0000_0000_0001, 2);
    run("mid", 64'h00FF_0000_0000_FF00, 16);

    // Backpressure: hold the result while an offered vector is ignored
    ready_i = 1'b0;
    send(64'h8000_0000_0000_0001);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1;
      data_i  = '1;
      tick();
      check("bp_valid_held", 64'(cur_valid), 64'd1);
      check("bp_cnt_held", 64'(cur_cnt), 64'd2);
      check("bp_ready_low", 64'(cur_ready), 64'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    check("bp_release_valid", 64'(cur_valid), 64'd0);
    check("bp_release_ready", 64'(cur_ready), 64'd1);
    run("b2b_first", 64'h1, 1);
    run("b2b_second", 64'h3, 2);

    // Abort in the third BUSY cycle
    ready_i = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("abort_valid", 64'(cur_valid), 64'd0);
    check("abort_ready", 64'(cur_ready), 64'd1);
    check("abort_cnt", 64'(cur_cnt), 64'd0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (cur_valid) seen = 1'b1;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run("after_abort", 64'hF0, 4);

    // clear_i together with valid_i in IDLE must not capture
    clear_i = 1'b1;
    valid_i = 1'b1;
    data_i  = '1;
    tick();
    clear_i = 1'b0;
    valid_i = 1'b0;
    check("clear_vs_valid_ready", 64'(cur_ready), 64'd1);
    check("clear_vs_valid_cnt", 64'(cur_cnt), 64'd0);

    // Reset while a result is pending
    ready_i = 1'b0;
    send(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(lat);
    check("rst_done_cnt_before", 64'(cur_cnt), 64'd64);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_done_valid", 64'(cur_valid), 64'd0);
    check("rst_done_cnt", 64'(cur_cnt), 64'd0);
    check("rst_done_ready", 64'(cur_ready), 64'd1);
    run("after_rst", 64'hF0F0, 8);

    random_run("rnd64", 3500);

    // Single-chunk build: one BUSY cycle
    sel  = 1'b1;
    nc   = 1;
    mask = 64'hFF;
    ready_i = 1'b0;
    tick();
    check("b_idle_ready", 64'(cur_ready), 64'd1);
    run("b_ones", 64'hFF, 8);
    run("b_ends", 64'h81, 2);
    run("b_zero", 64'h00, 0);
    random_run("rnd8", 3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
